// File: rtl/data_mem_responder.sv
// Word-wide load/store responder over a byte-wide internal store.
// Each valid request moves one byte per cycle (big-endian) before responding.
module data_mem_responder #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o,
  output logic [15:0]       access_count_o
);

  localparam int unsigned IdxW = $clog2(MEM_BYTES);
  localparam logic [ADDR_W-1:0] MaxAddr = ADDR_W'(MEM_BYTES - 4);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0] addr_q, addr_d;
  logic            write_q, write_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [15:0]     count_q, count_d;

  // Not covered by reset: contents must survive a reset.
  logic [7:0]      mem_q [MEM_BYTES] = '{default: 8'h00};

  logic            req_bad;
  logic            accept;
  logic            resp_done;
  logic [IdxW-1:0] idx;

  assign req_bad   = (req_addr_i[1:0] != 2'b00) || (req_addr_i > MaxAddr);
  assign accept    = (state_q == StIdle) && req_valid_i;
  assign resp_done = (state_q == StResp) && resp_ready_i;
  assign idx       = addr_q + IdxW'(cnt_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_valid_i) state_d = req_bad ? StResp : StAccess;
      StAccess: if (cnt_q == 2'd3) state_d = StResp;
      StResp:   if (resp_ready_i) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    count_d = count_q;
    if (accept) begin
      cnt_d   = 2'd0;
      addr_d  = req_addr_i[IdxW-1:0];
      write_d = req_write_i;
      wdata_d = req_wdata_i;
      rdata_d = 32'd0;
      err_d   = req_bad;
    end else if (state_q == StAccess) begin
      cnt_d   = cnt_q + 2'd1;
      // Store data shifts out MSB-first, load data shifts in MSB-first.
      wdata_d = {wdata_q[23:0], 8'h00};
      if (!write_q) rdata_d = {rdata_q[23:0], mem_q[idx]};
    end else if (resp_done) begin
      rdata_d = 32'd0;
      err_d   = 1'b0;
      if (!err_q) count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if ((state_q == StAccess) && write_q) mem_q[idx] <= wdata_q[31:24];
  end

  always_comb begin
    req_ready_o    = (state_q == StIdle);
    resp_valid_o   = (state_q == StResp);
    resp_rdata_o   = (state_q == StResp) ? rdata_q : 32'd0;
    resp_err_o     = (state_q == StResp) && err_q;
    access_count_o = count_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed and randomized checks of data_mem_responder against a byte-array model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [15:0] access_count;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem_m [1024];
  int         count_m = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.MEM_BYTES(1024), .ADDR_W(32)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_write_i    (req_write),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_rdata_o   (resp_rdata),
    .resp_err_o     (resp_err),
    .access_count_o (access_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, " resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, " resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, " access_count"}, 32'(access_count), 32'd0);
  endtask

  // One full transaction; hold = cycles resp_ready is kept low in RESP.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input int hold);
    logic        bad;
    logic [31:0] exp_rd;
    int          lat;
    bad = (a[1:0] != 2'b00) || (a > 32'd1020);
    exp_rd = 32'd0;
    if (!bad && !w) exp_rd = {mem_m[a], mem_m[a + 1], mem_m[a + 2], mem_m[a + 3]};
    @(negedge clk);
    chk("ready in idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'($urandom); req_write = ~w; req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    chk("latency", 32'(lat), bad ? 32'd1 : 32'd5);
    for (int i = 0; i < hold; i++) begin
      chk("hold rdata", resp_rdata, exp_rd);
      chk("hold err", 32'(resp_err), 32'(bad));
      chk("hold valid", 32'(resp_valid), 32'd1);
      chk("hold ready", 32'(req_ready), 32'd0);
      req_valid = 1'($urandom);
      @(negedge clk);
    end
    chk("resp rdata", resp_rdata, exp_rd);
    chk("resp err", 32'(resp_err), 32'(bad));
    resp_ready = 1'b1;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    req_valid = 1'b0;
    if (!bad) begin
      count_m = (count_m + 1) & 16'hFFFF;
      if (w) for (int k = 0; k < 4; k++) mem_m[a + k] = d[31 - 8 * k -: 8];
    end
    chk("exit valid", 32'(resp_valid), 32'd0);
    chk("exit rdata", resp_rdata, 32'd0);
    chk("exit err", 32'(resp_err), 32'd0);
    chk("exit count", 32'(access_count), 32'(count_m));
    chk("no same-edge accept", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int          rv_cyc[$];
    int          rr_n;
    logic [31:0] a;
    int          r;
    for (int i = 0; i < 1024; i++) mem_m[i] = 8'h00;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0;
    req_wdata = 32'd0; resp_ready = 1'b0;
    #2;
    chk_reset_outputs("reset at t0");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    xact(1'b1, 32'h10, 32'hDEADBEEF, 0);
    xact(1'b0, 32'h10, 32'h0, 0);
    chk("count after 2", 32'(access_count), 32'd2);

    xact(1'b1, 32'h20, 32'h11223344, 1);
    xact(1'b0, 32'h20, 32'h0, 0);
    chk("mem 0x20", 32'(dut.mem_q[32]), 32'h11);
    chk("mem 0x21", 32'(dut.mem_q[33]), 32'h22);
    chk("mem 0x22", 32'(dut.mem_q[34]), 32'h33);
    chk("mem 0x23", 32'(dut.mem_q[35]), 32'h44);

    xact(1'b0, 32'h13, 32'h0, 0);
    xact(1'b0, 32'h3FE, 32'h0, 0);
    xact(1'b1, 32'h13, 32'hFFFFFFFF, 0);
    xact(1'b1, 32'h400, 32'hFFFFFFFF, 0);
    xact(1'b0, 32'h10, 32'h0, 0);
    xact(1'b1, 32'h3FC, 32'hCAFEF00D, 0);
    xact(1'b0, 32'h3FC, 32'h0, 0);

    xact(1'b0, 32'h10, 32'h0, 10);

    // Abort a store after two bytes have been written.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'hAABBCCDD;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset mid-access");
    mem_m[32'h40] = 8'hAA;
    mem_m[32'h41] = 8'hBB;
    count_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    xact(1'b0, 32'h40, 32'h0, 0);
    chk("partial store word", {mem_m[32'h40], mem_m[32'h41], mem_m[32'h42], mem_m[32'h43]},
        32'hAABB0000);

    // Back-to-back loads with both handshakes tied high.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; resp_ready = 1'b1;
    rr_n = 0;
    for (int c = 0; c < 36; c++) begin
      if (req_ready) rr_n++;
      if (resp_valid) begin
        rv_cyc.push_back(c);
        chk("b2b rdata", resp_rdata, 32'hDEADBEEF);
      end
      if (c == 35) req_valid = 1'b0;
      @(negedge clk);
    end
    resp_ready = 1'b0;
    count_m += 6;
    chk("b2b ready cycles", 32'(rr_n), 32'd6);
    chk("b2b responses", 32'(rv_cyc.size()), 32'd6);
    if (rv_cyc.size() > 0) chk("b2b first resp", 32'(rv_cyc[0]), 32'd5);
    for (int i = 1; i < rv_cyc.size(); i++)
      chk("b2b spacing", 32'(rv_cyc[i] - rv_cyc[i - 1]), 32'd6);
    chk("b2b count", 32'(access_count), 32'(count_m));

    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = 32'($urandom_range(0, 15)) * 4;
      else if (r == 7) a = 32'($urandom_range(0, 1023));
      else if (r == 8) a = 32'd1016 + 32'($urandom_range(0, 11));
      else             a = $urandom;
      xact(1'($urandom), a, $urandom, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter MEM_BYTES, default 1024, byte capacity of the internal store (power of two, >= 4).
REQ-002 Parameter ADDR_W, default 32, request address width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low; asserted while 0.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = store word, 0 = load word.
REQ-008 req_addr  input  ADDR_W  byte address of the word.
REQ-009 req_wdata  input  32  store data.
REQ-010 resp_valid  output  1  response is presented.
REQ-011 resp_ready  input  1  initiator accepts the response.
REQ-012 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-013 resp_err  output  1  request was misaligned or out of range.
REQ-014 access_count  output  16  number of completed non-error accesses.

Function
REQ-015 States SHALL be IDLE, ACCESS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 Handshake: a request is accepted on a rising edge with req_valid=1 and req_ready=1; addr, write flag and wdata are latched at that edge, and later input changes have no effect.
REQ-017 Error check at acceptance: req_addr[1:0]!=0 or req_addr > MEM_BYTES-4 SHALL transition IDLE->RESP with resp_err=1, resp_rdata=0 and no memory change.
REQ-018 Valid request: IDLE->ACCESS with byte counter 0; ACCESS transfers one byte per cycle for counters 0..3, then moves to RESP on the edge that processes byte 3.
REQ-019 Byte order is big-endian: byte counter k maps to address addr+k and data bits [31-8k : 24-8k].
REQ-020 Store: each ACCESS cycle writes one byte of the latched wdata; load: each ACCESS cycle shifts one byte into the read buffer.
REQ-021 Latency: resp_valid SHALL assert 5 edges after acceptance for valid requests (acceptance edge counted as 1) and 1 edge after acceptance for errors.
REQ-022 In RESP, resp_valid=1 and resp_rdata/resp_err SHALL hold stable until an edge with resp_ready=1; on that edge state returns to IDLE, and resp_valid, resp_rdata and resp_err clear to 0.
REQ-023 A request cannot be accepted on the same edge a response completes; req_ready rises in the following cycle.
REQ-024 access_count SHALL increment by 1 on each RESP exit with resp_err=0 and wrap from 16'hFFFF to 0.
REQ-025 A load following a store to the same word SHALL return the stored data.
REQ-026 Memory contents SHALL be zero at simulation time 0 and SHALL NOT be altered by reset.

Reset
REQ-027 With rst=0, state SHALL be IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, access_count=0, byte counter=0, immediately and without waiting for a clock edge.
REQ-028 Reset asserted during ACCESS SHALL abort the access with no response; bytes already stored stay written, and the remaining bytes are not written.
REQ-029 After rst returns to 1, the first request SHALL be accepted on the next rising edge that has req_valid=1.

Verification
REQ-030 Store 32'hDEADBEEF to addr 0x10, then load 0x10 -> resp_rdata=32'hDEADBEEF, resp_err=0, resp_valid 5 edges after each acceptance, access_count=2.
REQ-031 Store 32'h11223344 to 0x20, then load 0x20 and confirm internal bytes 0x20..0x23 = 11,22,33,44 -> rdata 32'h11223344.
REQ-032 Load 0x13 (misaligned) and load 0x3FE (out of range, MEM_BYTES=1024) -> resp_err=1, rdata=0, 1-edge latency, access_count unchanged, memory unchanged.
REQ-033 Hold resp_ready=0 for 10 cycles in RESP -> resp_valid/rdata stable and req_ready=0 throughout; req_valid toggling is ignored.
REQ-034 Store 32'hAABBCCDD to 0x40 and assert rst after 2 ACCESS edges -> outputs at reset values immediately; subsequent load 0x40 returns 32'hAABB0000.
REQ-035 Back-to-back loads with resp_ready tied to 1 and req_valid tied to 1 -> one response every 6 cycles, req_ready=1 exactly one cycle per transaction.
